// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: valid/ready on both sides, registered in_ready, 2-entry skid buffer.
// Optional saturating performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int                 DATA_W = 96,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
    parameter int                 CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_xfer_cnt,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q,   in_ready_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              acc_s;
    logic              ret_s;

    assign acc_s = in_valid & in_ready_q;
    assign ret_s = main_valid_q & out_ready;

    // Next-state for both slots; flush dominates, data regs only load on a transfer.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = BUBBLE;
            skid_data_d  = BUBBLE;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    if (acc_s) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                    end else begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (acc_s && ret_s) begin
                        main_data_d = in_data;
                    end else if (acc_s) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else if (ret_s) begin
                        main_valid_d = 1'b0;
                        main_data_d  = BUBBLE;
                    end else begin
                        main_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    if (ret_s) begin
                        skid_valid_d = 1'b0;
                        main_data_d  = skid_data_q;
                        skid_data_d  = BUBBLE;
                    end else begin
                        skid_valid_d = 1'b1;
                    end
                end
                default: begin
                    // Orphaned skid entry cannot be ordered safely; drop to EMPTY.
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                    main_data_d  = BUBBLE;
                    skid_data_d  = BUBBLE;
                end
            endcase
        end
        in_ready_d = ~skid_valid_d;
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_data_q  <= BUBBLE;
            skid_data_q  <= BUBBLE;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] xfer_cnt_q,  xfer_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Counter next-state; a flush only counts when it actually killed data.
    always_comb begin
        xfer_cnt_d  = xfer_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ret_s) begin
            xfer_cnt_d = sat_inc(xfer_cnt_q);
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
        if (main_valid_q && !out_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush && (main_valid_q || skid_valid_q)) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q  <= {CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_xfer_cnt  = xfer_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    pipe_stage_skid_chk #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .main_valid (main_valid_q),
        .skid_valid (skid_valid_q),
        .out_ready  (out_ready),
        .out_data   (main_data_q)
    );

endmodule

// Simulation-time protocol checks for pipe_stage_skid.
module pipe_stage_skid_chk #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 32
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    input logic              main_valid,
    input logic              skid_valid,
    input logic              out_ready,
    input logic [DATA_W-1:0] out_data
);

    a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
        !(!main_valid && skid_valid));

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (main_valid && !out_ready && !flush) |=> $stable(out_data));

    a_cnt_w: assert property (@(posedge clk) CNT_W >= 2);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (DATA_W=32, BUBBLE=NOP, CNT_W=4).
module tb_pipe_stage_skid;

    localparam int          DW  = 32;
    localparam logic [31:0] BUB = 32'h0000_0013;
    localparam int          CW  = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] perf_xfer_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_xfer_cnt  (perf_xfer_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic r);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".out_data"},  out_data, d);
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, r});
    endtask

    initial begin
        logic [31:0] wide_pat [4];
        wide_pat[0] = 32'hDEAD_BEEF;
        wide_pat[1] = 32'hFFFF_FFFF;
        wide_pat[2] = 32'h0000_0000;
        wide_pat[3] = 32'h8000_0001;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        tick();
        tick();
        check_out("reset", 1'b0, BUB, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
        check("reset.xfer",  {28'd0, perf_xfer_cnt},  32'd0);
        check("reset.stall", {28'd0, perf_stall_cnt}, 32'd0);
        check("reset.flush", {28'd0, perf_flush_cnt}, 32'd0);
`endif
        rst = 1'b0;

        // Full-rate stream 1..8.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = i;
            tick();
            check_out($sformatf("stream%0d", i), 1'b1, i, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            in_data = wide_pat[i];
            tick();
            check_out($sformatf("wide%0d", i), 1'b1, wide_pat[i], 1'b1);
        end
        in_valid = 1'b0;
        tick();
        check_out("drain", 1'b0, BUB, 1'b1);

        // Back-pressure into the skid slot.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        check_out("bp_a", 1'b1, 32'hA, 1'b1);
        in_data = 32'hB;
        tick();
        check_out("bp_skid", 1'b1, 32'hA, 1'b0);
        in_data = 32'hC;
        tick();
        check_out("bp_hold", 1'b1, 32'hA, 1'b0);
        out_ready = 1'b1;
        tick();
        check_out("bp_b", 1'b1, 32'hB, 1'b1);
        tick();
        check_out("bp_c", 1'b1, 32'hC, 1'b1);
        in_valid = 1'b0;
        tick();
        check_out("bp_drain", 1'b0, BUB, 1'b1);

        // Flush while in SKID; offered 0x33 must be dropped.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        check_out("fl_skid", 1'b1, 32'h11, 1'b0);
        in_data = 32'h33; flush = 1'b1;
        tick();
        check_out("fl_after", 1'b0, BUB, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_out("fl_nodata", 1'b0, BUB, 1'b1);

        // Simultaneous accept and return in FULL.
        in_valid = 1'b1; in_data = 32'h5;
        tick();
        check_out("sim_5", 1'b1, 32'h5, 1'b1);
        out_ready = 1'b1; in_data = 32'h6;
        tick();
        check_out("sim_6", 1'b1, 32'h6, 1'b1);
        in_valid = 1'b0;
        tick();
        check_out("sim_drain", 1'b0, BUB, 1'b1);

        // Reset beats flush and accept while in SKID.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
        tick();
        in_data = 32'h8;
        tick();
        check_out("rst_skid", 1'b1, 32'h7, 1'b0);
        rst = 1'b1; flush = 1'b1; in_data = 32'h9;
        tick();
        check_out("rst_mid", 1'b0, BUB, 1'b1);
`ifdef PIPE_STAGE_PERF_EN
        check("rst_mid.xfer",  {28'd0, perf_xfer_cnt},  32'd0);
        check("rst_mid.stall", {28'd0, perf_stall_cnt}, 32'd0);
        check("rst_mid.flush", {28'd0, perf_flush_cnt}, 32'd0);
`endif
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        check_out("rst_idle", 1'b0, BUB, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter saturation at 4'hF.
        in_valid = 1'b1; in_data = 32'h44;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        check("perf_stall_sat", {28'd0, perf_stall_cnt}, 32'd15);
        tick();
        check("perf_stall_hold", {28'd0, perf_stall_cnt}, 32'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
